score_packer: RTL and testbench

Serial-to-parallel collector placed between the output layer and the argmax label stage. It accepts one n-bit class score per handshake, in label order 0 to number_of_labels-1. It packs the scores into a number_of_labels*n-bit vector in the argmax stage's input format and presents the completed frame with a valid/ready handshake. It also flags framing errors against the producer's last-marker.

---
 rtl/score_packer_pkg.sv | 14 +
 rtl/score_packer.sv | 105 ++++++++++
 tb/tb_score_packer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/score_packer_pkg.sv
// Shared MLP header: default widths for the score path and the
// collector FSM state encoding used by score_packer.
package score_packer_pkg;

    localparam int DEF_N                      = 8;
    localparam int DEF_NUMBER_OF_LABELS       = 10;
    localparam int DEF_CLOG2_NUMBER_OF_LABELS = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

endpackage

// File: rtl/score_packer.sv
// score_packer: serial-to-parallel collector between the output layer and
// the argmax label stage. Accepts one score per handshake in label order,
// presents the completed frame with valid/ready and keeps a sticky flag
// for frames whose last-marker disagrees with the score count.
module score_packer
    import score_packer_pkg::*;
#(
    parameter int n                      = DEF_N,
    parameter int number_of_labels       = DEF_NUMBER_OF_LABELS,
    parameter int clog2_number_of_labels = DEF_CLOG2_NUMBER_OF_LABELS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [n-1:0]                       in_score,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [number_of_labels*n-1:0]      numbers,
    output logic [clog2_number_of_labels-1:0]  idx,
    output logic                               frame_err
);

    // Index of the final slot of a frame; frame length is fixed by count.
    localparam logic [clog2_number_of_labels-1:0] LAST_IDX =
        clog2_number_of_labels'(number_of_labels - 1);

    state_t                             r_state;
    logic [clog2_number_of_labels-1:0]  r_idx;
    logic [n-1:0]                       r_slots [number_of_labels];
    logic                               r_frame_err;

    logic                               w_accept;
    logic                               w_last_slot;
    logic [number_of_labels-1:0]        w_slot_we;

    // A score is taken only while collecting; nothing is accepted in FULL.
    assign w_accept    = in_valid && (r_state == COLLECT);
    assign w_last_slot = (r_idx == LAST_IDX);

    // Per-slot write-enable decode and packing into the argmax input format
    // (label k occupies bits [n*k+n-1 -: n]).
    generate
        for (genvar gi = 0; gi < number_of_labels; gi++) begin : g_slot
            assign w_slot_we[gi]         = w_accept &&
                                           (r_idx == clog2_number_of_labels'(gi));
            assign numbers[gi*n +: n]    = r_slots[gi];
        end
    endgenerate

    // Slot storage: written on acceptance, never cleared on consume, so the
    // frame stays stable while FULL and is overwritten by the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < number_of_labels; k++) begin
                r_slots[k] <= '0;
            end
        end else begin
            for (int k = 0; k < number_of_labels; k++) begin
                if (w_slot_we[k]) begin
                    r_slots[k] <= in_score;
                end
            end
        end
    end

    // Collector FSM: index counter, frame hand-off and sticky framing check.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= COLLECT;
            r_idx       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        // last-marker must coincide exactly with the final slot
                        if (in_last != w_last_slot) begin
                            r_frame_err <= 1'b1;
                        end
                        if (w_last_slot) begin
                            r_idx   <= '0;
                            r_state <= FULL;
                        end else begin
                            r_idx <= r_idx + clog2_number_of_labels'(1);
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        r_state <= COLLECT;
                    end
                end
            endcase
        end
    end

    // All outputs decode registered state only.
    assign in_ready  = (r_state == COLLECT);
    assign out_valid = (r_state == FULL);
    assign idx       = r_idx;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_score_packer.sv
// Self-checking bench for score_packer: table-driven frame pack, directed
// multi-cycle corner sequences and randomized traffic against a count-based
// reference model.
module tb_score_packer;

    localparam int NL = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_score;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [79:0] numbers;
    logic [3:0]  idx;
    logic        frame_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: total accepted scores, frames consumed, slot contents.
    int         m_cnt;
    int         m_consumed;
    logic [7:0] m_slots [NL];
    logic       m_err;

    score_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_score  (in_score),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .numbers   (numbers),
        .idx       (idx),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] s;
        logic       l;
        logic       r;
        logic       e_in_ready;
        logic       e_out_valid;
        logic [3:0] e_idx;
        logic       e_err;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic m_full();
        return (m_cnt / NL) > m_consumed;
    endfunction

    function automatic logic [79:0] m_numbers();
        logic [79:0] v;
        for (int k = 0; k < NL; k++) v[k*8 +: 8] = m_slots[k];
        return v;
    endfunction

    task automatic m_reset();
        m_cnt      = 0;
        m_consumed = 0;
        m_err      = 1'b0;
        for (int k = 0; k < NL; k++) m_slots[k] = 8'd0;
    endtask

    // One clock: drive inputs, advance the model, compare every output.
    task automatic cycle(input logic v, input logic [7:0] s, input logic l,
                         input logic r, input logic rs);
        logic acc, cons;
        int   pos;
        in_valid  = v;
        in_score  = s;
        in_last   = l;
        out_ready = r;
        rst       = rs;
        acc  = v && !m_full();
        cons = m_full() && r;
        pos  = m_cnt % NL;
        @(posedge clk);
        #1;
        if (rs) begin
            m_reset();
            $display("reset");
        end else begin
            if (acc) begin
                m_slots[pos] = s;
                if (l != (pos == NL - 1)) m_err = 1'b1;
                m_cnt++;
                $display("accept slot %0d score %0d last %0d", pos, s, l);
            end
            if (cons) begin
                m_consumed++;
                $display("consume frame %0d", m_consumed);
            end
        end
        chk("in_ready",  {79'd0, in_ready},  {79'd0, !m_full()});
        chk("out_valid", {79'd0, out_valid}, {79'd0, m_full()});
        chk("idx",       {76'd0, idx},       80'(m_cnt % NL));
        chk("frame_err", {79'd0, frame_err}, {79'd0, m_err});
        chk("numbers",   numbers,            m_numbers());
    endtask

    int          rise_t [$];
    int          hi_cycles;
    logic        prev_ov;
    logic [79:0] snap;

    initial begin
        m_reset();
        in_valid = 0; in_score = 0; in_last = 0; out_ready = 0; rst = 1;

        // ---------------- reset state ----------------
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("rst_in_ready",  {79'd0, in_ready},  80'd1);
        chk("rst_out_valid", {79'd0, out_valid}, 80'd0);
        chk("rst_idx",       {76'd0, idx},       80'd0);
        chk("rst_numbers",   numbers,            80'd0);
        chk("rst_frame_err", {79'd0, frame_err}, 80'd0);

        // ---------------- frame pack (table) ----------------
        for (int i = 0; i < 10; i++) begin
            tbl[i] = '{1'b1, 8'(10*(i+1)), (i == 9), 1'b0,
                       (i < 9), (i == 9), 4'((i+1) % 10), 1'b0};
        end
        tbl[10] = '{1'b1, 8'd55, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].v, tbl[i].s, tbl[i].l, tbl[i].r, 0);
            chk("tbl_in_ready",  {79'd0, in_ready},  {79'd0, tbl[i].e_in_ready});
            chk("tbl_out_valid", {79'd0, out_valid}, {79'd0, tbl[i].e_out_valid});
            chk("tbl_idx",       {76'd0, idx},       {76'd0, tbl[i].e_idx});
            chk("tbl_frame_err", {79'd0, frame_err}, {79'd0, tbl[i].e_err});
        end
        chk("pack_slot0", {72'd0, numbers[7:0]},   80'd10);
        chk("pack_slot9", {72'd0, numbers[79:72]}, 80'd100);

        // ---------------- back-pressure ----------------
        snap = numbers;
        for (int i = 0; i < 5; i++) begin
            cycle(1, 8'd55, 0, 0, 0);
            chk("bp_numbers", numbers, snap);
            chk("bp_idx", {76'd0, idx}, 80'd0);
        end
        cycle(1, 8'd55, 0, 1, 0);
        chk("bp_release_in_ready",  {79'd0, in_ready},  80'd1);
        chk("bp_release_out_valid", {79'd0, out_valid}, 80'd0);
        chk("bp_release_slot0", numbers, snap);
        cycle(1, 8'd55, 0, 0, 0);
        chk("bp_accept_slot0", {72'd0, numbers[7:0]}, 80'd55);
        chk("bp_accept_idx",   {76'd0, idx},          80'd1);

        // ---------------- reset mid-frame ----------------
        for (int i = 1; i < 6; i++) cycle(1, 8'(200 + i), 0, 0, 0);
        chk("mid_idx_before", {76'd0, idx}, 80'd6);
        cycle(1, 8'd99, 0, 0, 1);
        chk("mid_idx",       {76'd0, idx},       80'd0);
        chk("mid_out_valid", {79'd0, out_valid}, 80'd0);
        chk("mid_numbers",   numbers,            80'd0);
        for (int i = 0; i < 10; i++) cycle(1, 8'(i + 1), (i == 9), 0, 0);
        for (int k = 0; k < 10; k++)
            chk("mid_fresh_slot", {72'd0, numbers[k*8 +: 8]}, 80'(k + 1));
        cycle(0, 0, 0, 1, 0);

        // ---------------- gapped input ----------------
        for (int c = 0; c < 19; c++) begin
            cycle(((c % 2) == 0), 8'(30 + c / 2), (c == 18), 0, 0);
            if (c == 17) chk("gap_not_yet", {79'd0, out_valid}, 80'd0);
        end
        chk("gap_done", {79'd0, out_valid}, 80'd1);
        for (int k = 0; k < 10; k++)
            chk("gap_slot", {72'd0, numbers[k*8 +: 8]}, 80'(30 + k));
        cycle(0, 0, 0, 1, 0);

        // ---------------- framing error ----------------
        for (int i = 0; i < 10; i++) begin
            cycle(1, 8'(70 + i), (i == 3 || i == 9), 0, 0);
            if (i == 2) chk("ferr_before", {79'd0, frame_err}, 80'd0);
            if (i == 3) chk("ferr_set",    {79'd0, frame_err}, 80'd1);
        end
        chk("ferr_frame_done", {79'd0, out_valid}, 80'd1);
        cycle(0, 0, 0, 1, 0);
        chk("ferr_after_consume", {79'd0, frame_err}, 80'd1);
        cycle(0, 0, 0, 0, 1);
        chk("ferr_cleared", {79'd0, frame_err}, 80'd0);

        // ---------------- streaming ----------------
        prev_ov   = out_valid;
        hi_cycles = 0;
        for (int c = 0; c < 34; c++) begin
            cycle(1, 8'(m_cnt), ((m_cnt % NL) == NL - 1), 1, 0);
            if (out_valid) hi_cycles++;
            if (out_valid && !prev_ov) rise_t.push_back(c);
            prev_ov = out_valid;
        end
        chk("stream_pulses",   80'(rise_t.size()), 80'd3);
        chk("stream_hi_width", 80'(hi_cycles),     80'd3);
        if (rise_t.size() == 3) begin
            chk("stream_period1", 80'(rise_t[1] - rise_t[0]), 80'd11);
            chk("stream_period2", 80'(rise_t[2] - rise_t[1]), 80'd11);
        end else begin
            chk("stream_period_pulses", 80'(rise_t.size()), 80'd3);
        end

        // ---------------- randomized traffic ----------------
        cycle(0, 0, 0, 0, 1);
        for (int c = 0; c < 400; c++) begin
            logic v, l, r, rs;
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 63) == 0);
            l  = ((m_cnt % NL) == NL - 1);
            if ($urandom_range(0, 15) == 0) l = !l;
            cycle(v, 8'($urandom), l, r, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
